cordic_gain_comp: RTL



---
 rtl/cordic_gain_comp.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cordic_gain_comp.sv
// Removes circular-mode CORDIC gain from x/y by a bit-serial shift-add multiply with 1/K.
// Define CORDIC_GAIN_COMP_ROUND_EN for round-half-up instead of floor.
module cordic_gain_comp #(
    parameter int WHOLE_BIT_WIDTH   = 3,
    parameter int DECIMAL_BIT_WIDTH = 13
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] x_in,
    input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] y_in,
    input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] z_in,
    input  logic [1:0]                                   coordinate_system_in,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] x_scaled,
    output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] y_scaled,
    output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] z_pass,
    output logic                                         out_valid,
    input  logic                                         out_ready
);

    localparam int W  = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH;
    localparam int AW = W + 1;
    localparam int CW = (DECIMAL_BIT_WIDTH > 1) ? $clog2(DECIMAL_BIT_WIDTH) : 1;

    localparam real K_REAL = 0.6072529350 * (2.0 ** DECIMAL_BIT_WIDTH);
    localparam logic [DECIMAL_BIT_WIDTH-1:0] K_INV = DECIMAL_BIT_WIDTH'($rtoi(K_REAL + 0.5));

`ifdef CORDIC_GAIN_COMP_ROUND_EN
    // Preload shifts right D times, so it contributes exactly one half LSB.
    localparam logic [AW-1:0] ACC_INIT = AW'(1) << (DECIMAL_BIT_WIDTH - 1);
`else
    localparam logic [AW-1:0] ACC_INIT = '0;
`endif

    typedef enum logic [1:0] {StIdle, StScale, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    x_op_q, y_op_q, z_q;
    logic [AW-1:0]   acc_x_q, acc_y_q;
    logic [AW-1:0]   acc_x_next, acc_y_next;
    logic            last_step;

    // acc <- (acc + b*op) >>> 1, one guard bit above the accumulator.
    function automatic logic [AW-1:0] shift_add(input logic [AW-1:0] acc,
                                                input logic [W-1:0]  op,
                                                input logic          b);
        logic [AW:0] sum;
        sum = {acc[AW-1], acc} + (b ? {{2{op[W-1]}}, op} : '0);
        return sum[AW:1];
    endfunction

    always_comb begin
        acc_x_next = shift_add(acc_x_q, x_op_q, K_INV[cnt_q]);
        acc_y_next = shift_add(acc_y_q, y_op_q, K_INV[cnt_q]);
        last_step  = (cnt_q == CW'(DECIMAL_BIT_WIDTH - 1));
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (coordinate_system_in == 2'd1) ? StScale : StHold;
                end
            end
            StScale: begin
                if (last_step) state_d = StHold;
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_op_q   <= '0;
            y_op_q   <= '0;
            z_q      <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            x_scaled <= '0;
            y_scaled <= '0;
            z_pass   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_op_q  <= x_in;
                        y_op_q  <= y_in;
                        z_q     <= z_in;
                        acc_x_q <= ACC_INIT;
                        acc_y_q <= ACC_INIT;
                        cnt_q   <= '0;
                        if (coordinate_system_in != 2'd1) begin
                            x_scaled <= x_in;
                            y_scaled <= y_in;
                            z_pass   <= z_in;
                        end
                    end
                end
                StScale: begin
                    acc_x_q <= acc_x_next;
                    acc_y_q <= acc_y_next;
                    if (last_step) begin
                        x_scaled <= acc_x_next[W-1:0];
                        y_scaled <= acc_y_next[W-1:0];
                        z_pass   <= z_q;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
